// File: rtl/target_gen_multi_if.sv
// Request/target bus between the game-control FSM and the target generator.
interface target_gen_multi_if #(
    parameter int LFSR_W      = 16,
    parameter int COORD_W     = 5,
    parameter int NUM_TARGETS = 2
);
    logic                           ena;
    logic                           new_game;
    logic                           respawn_req;
    logic [2:0]                     respawn_idx;
    logic                           seed_load;
    logic [LFSR_W-1:0]              seed_in;
    logic                           busy;
    logic                           targets_valid;
    logic                           fallback_used;
    logic [NUM_TARGETS*COORD_W-1:0] target_x_flat;
    logic [NUM_TARGETS*COORD_W-1:0] target_y_flat;

    modport master (
        output ena, new_game, respawn_req, respawn_idx, seed_load, seed_in,
        input  busy, targets_valid, fallback_used, target_x_flat, target_y_flat
    );

    modport slave (
        input  ena, new_game, respawn_req, respawn_idx, seed_load, seed_in,
        output busy, targets_valid, fallback_used, target_x_flat, target_y_flat
    );
endinterface

// File: rtl/target_gen_multi.sv
// Multi-slot pseudo-random target generator: fills NUM_TARGETS (x,y) slots
// from a free-running Fibonacci LFSR, windowed, optionally unique per batch,
// with bounded retries and a deterministic fallback placement.
module target_gen_multi #(
    parameter int                LFSR_W      = 16,
    parameter logic [LFSR_W-1:0] TAPS        = 16'hB400,
    parameter logic [LFSR_W-1:0] SEED        = 16'hACE1,
    parameter int                COORD_W     = 5,
    parameter int                NUM_TARGETS = 2,
    parameter int                X_MAX       = 31,
    parameter int                Y_MIN       = 30,
    parameter int                Y_MAX       = 31,
    parameter int                UNIQUE      = 1,
    parameter int                MAX_TRIES   = 15
) (
    input logic               clk,
    input logic               reset,
    target_gen_multi_if.slave bus
);
    typedef enum logic [1:0] {IDLE, GEN, RESP} state_t;

    localparam int                  FLAT_W   = NUM_TARGETS * COORD_W;
    localparam int                  TRY_W    = (MAX_TRIES < 1) ? 1 : $clog2(MAX_TRIES + 1);
    localparam logic [2:0]          LAST_IDX = 3'(NUM_TARGETS - 1);
    localparam logic [TRY_W-1:0]    TRY_LAST = TRY_W'(MAX_TRIES);
    localparam logic [COORD_W:0]    X_LIM    = (COORD_W + 1)'(X_MAX);
    localparam logic [COORD_W:0]    Y_LO     = (COORD_W + 1)'(Y_MIN);
    localparam logic [COORD_W:0]    Y_HI     = (COORD_W + 1)'(Y_MAX);
    localparam logic [COORD_W-1:0]  FB_Y     = COORD_W'(Y_MIN);
    localparam int unsigned         X_SPAN   = X_MAX + 1;

    state_t              state, state_nx;
    logic [LFSR_W-1:0]   lfsr, lfsr_step, seed_val;
    logic [2:0]          idx, idx_nx;
    logic [TRY_W-1:0]    tries, tries_nx;
    logic                tv_r, tv_nx;
    logic                fbu_r, fbu_nx;
    logic [FLAT_W-1:0]   x_flat, y_flat;
    logic [COORD_W-1:0]  cx, cy, fb_x, wr_x, wr_y;
    logic                in_window, collision, accept, wr_en;

    assign lfsr_step = {lfsr[LFSR_W-2:0], ^(lfsr & TAPS)};
    assign seed_val  = (bus.seed_in == '0) ? SEED : bus.seed_in;

    assign cx        = lfsr[COORD_W-1:0];
    assign cy        = lfsr[2*COORD_W-1:COORD_W];
    assign in_window = ({1'b0, cx} <= X_LIM) && ({1'b0, cy} >= Y_LO) && ({1'b0, cy} <= Y_HI);
    assign accept    = in_window && !((UNIQUE != 0) && collision);
    assign fb_x      = COORD_W'(32'(idx) % X_SPAN);

    // Candidate collides with a slot already valid in this batch (GEN: below idx; RESP: all others)
    always_comb begin
        collision = 1'b0;
        for (int unsigned k = 0; k < NUM_TARGETS; k++) begin
            if (((state == GEN) ? (k < 32'(idx)) : (k != 32'(idx))) &&
                (x_flat[k*COORD_W +: COORD_W] == cx) &&
                (y_flat[k*COORD_W +: COORD_W] == cy)) begin
                collision = 1'b1;
            end
        end
    end

    // Next-state, slot write selection and status flag updates
    always_comb begin
        state_nx = state;
        idx_nx   = idx;
        tries_nx = tries;
        tv_nx    = tv_r;
        fbu_nx   = fbu_r;
        wr_en    = 1'b0;
        wr_x     = cx;
        wr_y     = cy;
        case (state)
            IDLE: begin
                if (bus.new_game) begin
                    state_nx = GEN;
                    idx_nx   = '0;
                    tries_nx = '0;
                    tv_nx    = 1'b0;
                    fbu_nx   = 1'b0;
                end else if (bus.respawn_req && (32'(bus.respawn_idx) < NUM_TARGETS)) begin
                    state_nx = RESP;
                    idx_nx   = bus.respawn_idx;
                    tries_nx = '0;
                    fbu_nx   = 1'b0;
                end
            end
            GEN, RESP: begin
                if (bus.new_game) begin
                    state_nx = GEN;
                    idx_nx   = '0;
                    tries_nx = '0;
                    tv_nx    = 1'b0;
                    fbu_nx   = 1'b0;
                end else if (accept || (tries == TRY_LAST)) begin
                    wr_en    = 1'b1;
                    tries_nx = '0;
                    if (!accept) begin
                        wr_x   = fb_x;
                        wr_y   = FB_Y;
                        fbu_nx = 1'b1;
                    end
                    if ((state == RESP) || (idx == LAST_IDX)) begin
                        state_nx = IDLE;
                        if (state == GEN) tv_nx = 1'b1;
                    end else begin
                        idx_nx = idx + 3'd1;
                    end
                end else begin
                    tries_nx = tries + TRY_W'(1);
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // State, LFSR and slot registers; everything holds while ena is low
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lfsr   <= SEED;
            state  <= IDLE;
            idx    <= '0;
            tries  <= '0;
            tv_r   <= 1'b0;
            fbu_r  <= 1'b0;
            x_flat <= '0;
            y_flat <= '0;
        end else if (bus.ena) begin
            lfsr  <= bus.seed_load ? seed_val : lfsr_step;
            state <= state_nx;
            idx   <= idx_nx;
            tries <= tries_nx;
            tv_r  <= tv_nx;
            fbu_r <= fbu_nx;
            for (int unsigned k = 0; k < NUM_TARGETS; k++) begin
                if (wr_en && (idx == 3'(k))) begin
                    x_flat[k*COORD_W +: COORD_W] <= wr_x;
                    y_flat[k*COORD_W +: COORD_W] <= wr_y;
                end
            end
        end
    end

    assign bus.busy          = (state != IDLE);
    assign bus.targets_valid = tv_r;
    assign bus.fallback_used = fbu_r;
    assign bus.target_x_flat = x_flat;
    assign bus.target_y_flat = y_flat;
endmodule

// File: tb/tb_target_gen_multi.sv
// Testbench for target_gen_multi: seed vector table, randomized games and
// respawns against a reference model, plus restart/freeze/reset sequences.
module tb_target_gen_multi;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    target_gen_multi_if #(.LFSR_W(16), .COORD_W(5), .NUM_TARGETS(2)) b ();
    target_gen_multi_if #(.LFSR_W(16), .COORD_W(5), .NUM_TARGETS(8)) b8 ();

    target_gen_multi dut (.clk(clk), .reset(reset), .bus(b));
    target_gen_multi #(.NUM_TARGETS(8), .X_MAX(3), .Y_MIN(31), .Y_MAX(31), .MAX_TRIES(2))
        dut8 (.clk(clk), .reset(reset), .bus(b8));

    typedef struct {
        logic        ld;
        logic [15:0] sin;
        logic [15:0] exp_lfsr;
    } seed_vec_t;

    int n_chk  = 0;
    int n_pass = 0;

    logic [15:0] m, m8, pl;
    int ex[8], ey[8];
    int efb, ecyc;

    function automatic void chk(string name, longint act, longint exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: actual %0h required %0h", name, act, exp);
    endfunction

    // Spec LFSR rule: shift left, feedback = parity of tapped bits
    function automatic logic [15:0] lstep(logic [15:0] v);
        return {v[14:0], 1'($countones(v & 16'hB400) % 2)};
    endfunction

    function automatic logic [15:0] seedsub(logic [15:0] v);
        return (v == 16'h0) ? 16'hACE1 : v;
    endfunction

    // Place one slot: draw up to maxt+1 candidates from pl, else fall back
    function automatic void place(input int s, input bit resp, input int nt,
                                  input int xmax, input int ymin, input int ymax,
                                  input int maxt);
        for (int t = 0; t <= maxt; t++) begin
            int cx, cy;
            bit ok;
            pl   = lstep(pl);
            ecyc++;
            cx   = int'(pl[4:0]);
            cy   = int'(pl[9:5]);
            ok   = (cx <= xmax) && (cy >= ymin) && (cy <= ymax);
            for (int j = 0; j < nt; j++)
                if ((resp ? (j != s) : (j < s)) && ex[j] == cx && ey[j] == cy) ok = 1'b0;
            if (ok) begin
                ex[s] = cx;
                ey[s] = cy;
                return;
            end
        end
        ex[s] = s % (xmax + 1);
        ey[s] = ymin;
        efb   = 1;
    endfunction

    function automatic int gx(int k);  return int'(b.target_x_flat[k*5 +: 5]);  endfunction
    function automatic int gy(int k);  return int'(b.target_y_flat[k*5 +: 5]);  endfunction
    function automatic int gx8(int k); return int'(b8.target_x_flat[k*5 +: 5]); endfunction
    function automatic int gy8(int k); return int'(b8.target_y_flat[k*5 +: 5]); endfunction

    task automatic tick();
        if (b.ena)  m  = b.seed_load  ? seedsub(b.seed_in)  : lstep(m);
        if (b8.ena) m8 = b8.seed_load ? seedsub(b8.seed_in) : lstep(m8);
        @(posedge clk);
        #1;
    endtask

    function automatic void check_slots2(string tag);
        for (int k = 0; k < 2; k++) begin
            chk({tag, " x"}, gx(k), ex[k]);
            chk({tag, " y"}, gy(k), ey[k]);
        end
        chk({tag, " fallback"}, b.fallback_used, efb);
    endfunction

    task automatic run_game();
        int cnt;
        b.new_game = 1'b1;
        pl = m;
        tick();
        b.new_game = 1'b0;
        efb = 0; ecyc = 0;
        for (int s = 0; s < 2; s++) place(s, 1'b0, 2, 31, 30, 31, 15);
        chk("game busy", b.busy, 1);
        chk("game tv low", b.targets_valid, 0);
        cnt = 0;
        while (!b.targets_valid && cnt < 200) begin tick(); cnt++; end
        chk("game latency", cnt, ecyc);
        chk("game busy done", b.busy, 0);
        check_slots2("game");
        for (int k = 0; k < 2; k++) chk("game y window", (gy(k) >= 30), 1);
        if (efb == 0) chk("game distinct", (gx(0) != gx(1)) || (gy(0) != gy(1)), 1);
    endtask

    task automatic do_respawn(int r);
        int cnt;
        b.respawn_req = 1'b1;
        b.respawn_idx = 3'(r);
        pl = m;
        tick();
        b.respawn_req = 1'b0;
        if (r < 2) begin
            efb = 0; ecyc = 0;
            place(r, 1'b1, 2, 31, 30, 31, 15);
            chk("resp busy", b.busy, 1);
            cnt = 0;
            while (b.busy && cnt < 100) begin tick(); cnt++; end
            chk("resp latency", cnt, ecyc);
            if (efb == 0) chk("resp distinct", (gx(0) != gx(1)) || (gy(0) != gy(1)), 1);
        end else begin
            chk("resp ignored busy", b.busy, 0);
        end
        chk("resp tv kept", b.targets_valid, 1);
        check_slots2("resp");
    endtask

    initial begin
        seed_vec_t tbl[5];
        int cnt, found, r;

        tbl[0] = '{1'b1, 16'h0000, 16'hACE1};
        tbl[1] = '{1'b1, 16'h1234, 16'h1234};
        tbl[2] = '{1'b0, 16'h0000, 16'h2469};
        tbl[3] = '{1'b0, 16'h0000, 16'h48D2};
        tbl[4] = '{1'b1, 16'hBEEF, 16'hBEEF};

        reset = 1'b1;
        b.ena = 0;  b.new_game = 0;  b.respawn_req = 0;  b.respawn_idx = 0;  b.seed_load = 0;  b.seed_in = 0;
        b8.ena = 0; b8.new_game = 0; b8.respawn_req = 0; b8.respawn_idx = 0; b8.seed_load = 0; b8.seed_in = 0;
        m = 16'hACE1;
        m8 = 16'hACE1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset busy", b.busy, 0);
        chk("reset tv", b.targets_valid, 0);
        chk("reset fallback", b.fallback_used, 0);
        chk("reset x_flat", b.target_x_flat, 0);
        chk("reset y_flat", b.target_y_flat, 0);
        reset = 1'b0;
        chk("reset lfsr", dut.lfsr, 16'hACE1);
        b.ena = 1'b1;
        tick();
        chk("lfsr step1", dut.lfsr, 16'h59C3);
        tick();
        chk("lfsr step2", dut.lfsr, m);
        chk("idle busy", b.busy, 0);
        chk("idle tv", b.targets_valid, 0);
        chk("idle x_flat", b.target_x_flat, 0);

        // Seed load table (zero substitutes SEED; no FSM effect)
        for (int i = 0; i < 5; i++) begin
            b.seed_load = tbl[i].ld;
            b.seed_in   = tbl[i].sin;
            tick();
            chk("seed_vec lfsr", dut.lfsr, tbl[i].exp_lfsr);
            chk("seed_vec busy", b.busy, 0);
        end
        b.seed_load = 1'b0;

        // Randomized games with optional reseed and respawn
        for (int g = 0; g < 500; g++) begin
            repeat ($urandom_range(2, 0)) tick();
            if ($urandom_range(3, 0) == 0) begin
                b.seed_load = 1'b1;
                b.seed_in   = 16'($urandom);
                tick();
                b.seed_load = 1'b0;
            end
            run_game();
            if ($urandom_range(1, 0) == 1) begin
                r = $urandom_range(2, 0);
                do_respawn((r == 2) ? 5 : r);
            end
        end
        do_respawn(1);
        do_respawn(5);

        // Only four legal points for eight unique slots: fallback must occur
        b8.ena = 1'b1;
        tick();
        b8.new_game = 1'b1;
        pl = m8;
        tick();
        b8.new_game = 1'b0;
        efb = 0; ecyc = 0;
        for (int s = 0; s < 8; s++) place(s, 1'b0, 8, 3, 31, 31, 2);
        cnt = 0;
        while (!b8.targets_valid && cnt < 40) begin tick(); cnt++; end
        chk("fb8 latency", cnt, ecyc);
        chk("fb8 fallback_used", b8.fallback_used, 1);
        found = 0;
        for (int k = 0; k < 8; k++) begin
            chk("fb8 x", gx8(k), ex[k]);
            chk("fb8 y", gy8(k), ey[k]);
            if (gx8(k) == (k % 4) && gy8(k) == 31) found++;
        end
        chk("fb8 fallback slot present", (found > 0), 1);
        b8.ena = 1'b0;

        // new_game mid-GEN restarts at slot 0, then a 3-cycle ena freeze
        b.new_game = 1'b1;
        tick();
        b.new_game = 1'b0;
        tick();
        b.new_game = 1'b1;
        pl = m;
        tick();
        b.new_game = 1'b0;
        efb = 0; ecyc = 0;
        for (int s = 0; s < 2; s++) place(s, 1'b0, 2, 31, 30, 31, 15);
        chk("restart busy", b.busy, 1);
        chk("restart tv", b.targets_valid, 0);
        tick();
        cnt = 1;
        b.ena = 1'b0;
        b.new_game = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("freeze lfsr", dut.lfsr, m);
            chk("freeze busy", b.busy, 1);
        end
        b.ena = 1'b1;
        b.new_game = 1'b0;
        while (!b.targets_valid && cnt < 200) begin tick(); cnt++; end
        chk("restart latency", cnt, ecyc);
        check_slots2("restart");

        // Asynchronous reset in the middle of generation
        b.new_game = 1'b1;
        tick();
        b.new_game = 1'b0;
        tick();
        chk("midgen busy", b.busy, 1);
        #2 reset = 1'b1;
        #1;
        chk("async reset busy", b.busy, 0);
        chk("async reset tv", b.targets_valid, 0);
        chk("async reset fallback", b.fallback_used, 0);
        chk("async reset x_flat", b.target_x_flat, 0);
        chk("async reset y_flat", b.target_y_flat, 0);
        chk("async reset lfsr", dut.lfsr, 16'hACE1);
        @(posedge clk);
        #1;
        reset = 1'b0;
        m = 16'hACE1;
        run_game();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
